core_bus_arbiter: RTL

//  Shares one req/gnt/rvalid memory port between the core's instruction-fetch and data-access masters.

---
 rtl/core_bus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one req/gnt/rvalid memory port between the
// instruction-fetch and data-access masters. Fixed priority (data first)
// with a starvation guard for fetch, address phases held stable while the
// memory stalls, and an owner FIFO so in-order responses go back to the
// master that issued them.
//
// state      | meaning
// -----------|------------------------------------------------------------
// ARB_FREE   | no stalled address phase; a new selection is made each cycle
// ARB_LOCKED | an address phase is waiting for bus_gnt_i; selection frozen
module core_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic held_sel_q, held_sel_d;
    logic sel;        // 0 = instr, 1 = data
    logic sel_req;
    logic bus_req;
    logic accept;
    logic push;
    logic pop;
    logic head;
    logic [CW-1:0] cnt_q, cnt_d, widx;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;

    // Master selection, request qualification and lock/unlock transitions
    always_comb begin
        state_d    = state_q;
        held_sel_d = held_sel_q;
        sel        = held_sel_q;
        if (state_q == ARB_FREE) begin
            if (instr_req_i && data_req_i && (starve_q == STARVE_MAX)) begin
                sel = 1'b0;
            end else begin
                sel = data_req_i;
            end
        end
        sel_req = sel ? data_req_i : instr_req_i;
        // a response popping this cycle frees a slot for a same-cycle push
        bus_req = sel_req && ((cnt_q < CNT_MAX) || bus_rvalid_i);
        accept  = bus_req && bus_gnt_i;
        if (accept) begin
            state_d = ARB_FREE;
        end else if (bus_req) begin
            state_d    = ARB_LOCKED;
            held_sel_d = sel;
        end
    end

    // Owner FIFO: entry 0 is the head; a pop shifts everything down one slot
    always_comb begin
        push    = accept;
        pop     = bus_rvalid_i && (cnt_q != '0);
        head    = owner_q[0];
        widx    = cnt_q - CW'(pop);
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (pop) begin
            owner_d = owner_q >> 1;
        end
        if (push) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (widx == CW'(i)) begin
                    owner_d[i] = sel;
                end
            end
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Starvation counter: consecutive data grants while fetch keeps waiting
    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i) begin
            starve_d = '0;
        end else if (accept && !sel) begin
            starve_d = '0;
        end else if (accept && sel && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Output routing; everything is forced low while reset is asserted
    always_comb begin
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        instr_rdata_o  = '0;
        data_rdata_o   = '0;
        instr_err_o    = 1'b0;
        data_err_o     = 1'b0;
        bus_req_o      = 1'b0;
        bus_we_o       = 1'b0;
        bus_be_o       = '0;
        bus_addr_o     = '0;
        bus_wdata_o    = '0;
        if (!rst) begin
            bus_req_o      = bus_req;
            instr_gnt_o    = accept && !sel;
            data_gnt_o     = accept && sel;
            bus_addr_o     = sel ? data_addr_i : instr_addr_i;
            bus_we_o       = sel && data_we_i;
            bus_be_o       = sel ? data_be_i : 4'hF;
            bus_wdata_o    = sel ? data_wdata_i : 32'h0;
            instr_rvalid_o = pop && !head;
            data_rvalid_o  = pop && head;
            instr_rdata_o  = bus_rdata_i;
            data_rdata_o   = bus_rdata_i;
            instr_err_o    = bus_err_i && pop && !head;
            data_err_o     = bus_err_i && pop && head;
        end
    end

    // State, FIFO and starvation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_FREE;
            held_sel_q <= 1'b0;
            cnt_q      <= '0;
            owner_q    <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            held_sel_q <= held_sel_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
        end
    end

endmodule
